// File: rtl/bridge_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the device bridge.
// The slave modport is the arbiter's view; the master modport is the requesters' and bridge's view.
interface bridge_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned DATA_W = 32;

  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_we;
  logic              m0_done;
  logic              m0_err;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_we;
  logic              m1_done;
  logic              m1_err;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] dev_addr;
  logic [DATA_W-1:0] dev_wdata;
  logic              dev_we;
  logic [DATA_W-1:0] dev_rdata;
  logic              busy;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_we,
    input  m1_req, m1_addr, m1_wdata, m1_we,
    input  dev_rdata,
    output m0_done, m0_err, m0_rdata,
    output m1_done, m1_err, m1_rdata,
    output dev_addr, dev_wdata, dev_we, busy
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_we,
    output m1_req, m1_addr, m1_wdata, m1_we,
    output dev_rdata,
    input  m0_done, m0_err, m0_rdata,
    input  m1_done, m1_err, m1_rdata,
    input  dev_addr, dev_wdata, dev_we, busy
  );
endinterface

// File: rtl/bridge_bus_arbiter.sv
// Round-robin two-master arbiter for the timer device bus: one single-word
// transaction at a time, held for ACCESS_CYCLES, with address filtering and done/err/rdata return.
module bridge_bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter int unsigned ADDR_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  bridge_bus_arbiter_if.slave  bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;
  logic              gid;
  logic              we_lat;
  logic              err_lat;

  logic              req_any_c;
  logic              grant1_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic              sel_we_c;
  logic              sel_err_c;
  logic [DATA_W-1:0] rdata_c;

  // Only word-aligned addresses inside Timer0 or Timer1 reach the device.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic in_t0;
    logic in_t1;
    in_t0 = (a >= ADDR_W'(32'h0000_7f00)) && (a <= ADDR_W'(32'h0000_7f0b));
    in_t1 = (a >= ADDR_W'(32'h0000_7f10)) && (a <= ADDR_W'(32'h0000_7f1b));
    return (a[1:0] == 2'b00) && (in_t0 || in_t1);
  endfunction

  // Grant selection: a tie goes to the master that was not granted last.
  always_comb begin
    req_any_c   = bus.m0_req | bus.m1_req;
    grant1_c    = bus.m1_req & (~bus.m0_req | ~last_grant);
    sel_addr_c  = grant1_c ? bus.m1_addr  : bus.m0_addr;
    sel_wdata_c = grant1_c ? bus.m1_wdata : bus.m0_wdata;
    sel_we_c    = grant1_c ? bus.m1_we    : bus.m0_we;
    sel_err_c   = ~addr_ok(sel_addr_c);
    rdata_c     = (err_lat | we_lat) ? '0 : bus.dev_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b1;
      gid           <= 1'b0;
      we_lat        <= 1'b0;
      err_lat       <= 1'b0;
      bus.m0_done   <= 1'b0;
      bus.m0_err    <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_done   <= 1'b0;
      bus.m1_err    <= 1'b0;
      bus.m1_rdata  <= '0;
      bus.dev_addr  <= '0;
      bus.dev_wdata <= '0;
      bus.dev_we    <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.m0_done <= 1'b0;
      bus.m1_done <= 1'b0;
      bus.dev_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any_c) begin
            gid           <= grant1_c;
            last_grant    <= grant1_c;
            bus.dev_addr  <= sel_addr_c;
            bus.dev_wdata <= sel_wdata_c;
            we_lat        <= sel_we_c;
            err_lat       <= sel_err_c;
            // The single write strobe lines up with the first access cycle.
            bus.dev_we    <= sel_we_c & ~sel_err_c;
            cnt           <= '0;
            bus.busy      <= 1'b1;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= RESP;
            if (gid) begin
              bus.m1_done  <= 1'b1;
              bus.m1_err   <= err_lat;
              bus.m1_rdata <= rdata_c;
            end else begin
              bus.m0_done  <= 1'b1;
              bus.m0_err   <= err_lat;
              bus.m0_rdata <= rdata_c;
            end
          end
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bridge_bus_arbiter.sv
// Directed bench for bridge_bus_arbiter: a vector table on an ACCESS_CYCLES=1 instance,
// plus hand sequences for the multi-cycle window and mid-access reset on an ACCESS_CYCLES=3 instance.
module tb_bridge_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bridge_bus_arbiter_if #(.ADDR_W(32)) b1 ();
  bridge_bus_arbiter_if #(.ADDR_W(32)) b3 ();

  bridge_bus_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(32)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  bridge_bus_arbiter #(.ACCESS_CYCLES(3), .ADDR_W(32)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  typedef struct {
    logic        r0, r1;
    logic [31:0] a0, a1;
    logic        we0, we1;
    logic [31:0] wd0, wd1;
    logic [31:0] drd;
    logic        gid;
    logic        err;
    logic        wep;
    logic [31:0] rd;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] model_rd [2];
    logic [31:0] ga, gw;
    int busy_cnt;

    b1.m0_req = 0; b1.m0_addr = 0; b1.m0_wdata = 0; b1.m0_we = 0;
    b1.m1_req = 0; b1.m1_addr = 0; b1.m1_wdata = 0; b1.m1_we = 0;
    b1.dev_rdata = 0;
    b3.m0_req = 0; b3.m0_addr = 0; b3.m0_wdata = 0; b3.m0_we = 0;
    b3.m1_req = 0; b3.m1_addr = 0; b3.m1_wdata = 0; b3.m1_we = 0;
    b3.dev_rdata = 0;
    model_rd[0] = 0;
    model_rd[1] = 0;

    //          r0 r1 a0            a1            we0 we1 wd0           wd1           drd           gid err wep rd
    vecs[0]  = '{1, 0, 32'h7f04,    32'h0,        1,  0,  32'h10,       32'h0,        32'h0,        0,  0,  1,  32'h0};
    vecs[1]  = '{0, 1, 32'h0,       32'h7f18,     0,  0,  32'h0,        32'h0,        32'hABCD0001, 1,  0,  0,  32'hABCD0001};
    vecs[2]  = '{1, 1, 32'h7f00,    32'h7f14,     0,  1,  32'h0,        32'h55,       32'h11111111, 0,  0,  0,  32'h11111111};
    vecs[3]  = '{1, 1, 32'h7f00,    32'h7f14,     0,  1,  32'h0,        32'h55,       32'h22222222, 1,  0,  1,  32'h0};
    vecs[4]  = '{1, 1, 32'h7f00,    32'h7f14,     0,  1,  32'h0,        32'h55,       32'h33333333, 0,  0,  0,  32'h33333333};
    vecs[5]  = '{1, 1, 32'h7f00,    32'h7f14,     0,  1,  32'h0,        32'h55,       32'h44444444, 1,  0,  1,  32'h0};
    vecs[6]  = '{1, 0, 32'h7f0c,    32'h0,        1,  0,  32'h99,       32'h0,        32'h0,        0,  1,  0,  32'h0};
    vecs[7]  = '{1, 0, 32'h7f02,    32'h0,        1,  0,  32'h77,       32'h0,        32'h0,        0,  1,  0,  32'h0};
    vecs[8]  = '{1, 0, 32'h7f1c,    32'h0,        0,  0,  32'h0,        32'h0,        32'h0000dead, 0,  1,  0,  32'h0};
    vecs[9]  = '{0, 1, 32'h0,       32'h7f08,     0,  0,  32'h0,        32'h0,        32'hCAFEF00D, 1,  0,  0,  32'hCAFEF00D};
    vecs[10] = '{0, 1, 32'h0,       32'h7f1e,     0,  0,  32'h0,        32'h0,        32'h0000beef, 1,  1,  0,  32'h0};
    vecs[11] = '{1, 0, 32'h7f10,    32'h0,        0,  0,  32'h0,        32'h0,        32'h12345678, 0,  0,  0,  32'h12345678};
    vecs[12] = '{1, 0, 32'h7efc,    32'h0,        0,  0,  32'h0,        32'h0,        32'h87654321, 0,  1,  0,  32'h0};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy",   32'(b1.busy),    32'h0);
    chk("rst_dev_we", 32'(b1.dev_we),  32'h0);
    chk("rst_daddr",  b1.dev_addr,     32'h0);
    chk("rst_dwdata", b1.dev_wdata,    32'h0);
    chk("rst_done0",  32'(b1.m0_done), 32'h0);
    chk("rst_done1",  32'(b1.m1_done), 32'h0);
    chk("rst_err0",   32'(b1.m0_err),  32'h0);
    chk("rst_err1",   32'(b1.m1_err),  32'h0);
    chk("rst_rdata0", b1.m0_rdata,     32'h0);
    chk("rst_rdata1", b1.m1_rdata,     32'h0);
    reset = 1'b0;

    // Each vector: IDLE (apply) -> ACCESS -> RESP -> IDLE.
    for (int i = 0; i < NV; i++) begin
      b1.m0_req = vecs[i].r0;  b1.m0_addr = vecs[i].a0;  b1.m0_we = vecs[i].we0;  b1.m0_wdata = vecs[i].wd0;
      b1.m1_req = vecs[i].r1;  b1.m1_addr = vecs[i].a1;  b1.m1_we = vecs[i].we1;  b1.m1_wdata = vecs[i].wd1;
      b1.dev_rdata = vecs[i].drd;
      ga = vecs[i].gid ? vecs[i].a1  : vecs[i].a0;
      gw = vecs[i].gid ? vecs[i].wd1 : vecs[i].wd0;

      @(negedge clk);
      chk($sformatf("v%0d acc_busy", i),   32'(b1.busy),   32'h1);
      chk($sformatf("v%0d acc_daddr", i),  b1.dev_addr,    ga);
      chk($sformatf("v%0d acc_dwdata", i), b1.dev_wdata,   gw);
      chk($sformatf("v%0d acc_dev_we", i), 32'(b1.dev_we), 32'(vecs[i].wep));
      chk($sformatf("v%0d acc_nodone", i), 32'(b1.m0_done | b1.m1_done), 32'h0);

      @(negedge clk);
      model_rd[vecs[i].gid] = vecs[i].rd;
      chk($sformatf("v%0d resp_done0", i), 32'(b1.m0_done), 32'(!vecs[i].gid));
      chk($sformatf("v%0d resp_done1", i), 32'(b1.m1_done), 32'(vecs[i].gid));
      chk($sformatf("v%0d resp_err", i),   32'(vecs[i].gid ? b1.m1_err : b1.m0_err), 32'(vecs[i].err));
      chk($sformatf("v%0d resp_rdata0", i), b1.m0_rdata, model_rd[0]);
      chk($sformatf("v%0d resp_rdata1", i), b1.m1_rdata, model_rd[1]);
      chk($sformatf("v%0d resp_dev_we", i), 32'(b1.dev_we), 32'h0);
      if (vecs[i].gid) b1.m1_req = 1'b0;
      else             b1.m0_req = 1'b0;

      @(negedge clk);
      chk($sformatf("v%0d idle_busy", i),  32'(b1.busy), 32'h0);
      chk($sformatf("v%0d idle_done", i),  32'(b1.m0_done | b1.m1_done), 32'h0);
      chk($sformatf("v%0d idle_daddr", i), b1.dev_addr, ga);
      chk($sformatf("v%0d idle_dev_we", i), 32'(b1.dev_we), 32'h0);
    end
    b1.m0_req = 1'b0;
    b1.m1_req = 1'b0;

    // ACCESS_CYCLES=3 read: address held three cycles, data taken from the third.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    b3.m1_req = 1'b1; b3.m1_addr = 32'h7f18; b3.m1_we = 1'b0; b3.dev_rdata = 32'h0;
    busy_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (b3.busy) busy_cnt++;
      chk($sformatf("ac3 acc%0d_daddr", k),  b3.dev_addr,      32'h7f18);
      chk($sformatf("ac3 acc%0d_dev_we", k), 32'(b3.dev_we),   32'h0);
      chk($sformatf("ac3 acc%0d_nodone", k), 32'(b3.m1_done),  32'h0);
      b3.dev_rdata = (k == 2) ? 32'h33330003 : 32'h11110000 + 32'(k);
    end
    @(negedge clk);
    if (b3.busy) busy_cnt++;
    chk("ac3 resp_done1", 32'(b3.m1_done), 32'h1);
    chk("ac3 resp_err1",  32'(b3.m1_err),  32'h0);
    chk("ac3 resp_rdata", b3.m1_rdata,     32'h33330003);
    b3.m1_req = 1'b0;
    b3.dev_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("ac3 busy_cycles", 32'(busy_cnt), 32'h4);
    chk("ac3 idle_busy",  32'(b3.busy),    32'h0);
    chk("ac3 idle_done",  32'(b3.m1_done), 32'h0);
    chk("ac3 rdata_held", b3.m1_rdata,     32'h33330003);

    // Write aborted by reset in its second access cycle.
    b3.m0_req = 1'b1; b3.m0_addr = 32'h7f00; b3.m0_we = 1'b1; b3.m0_wdata = 32'hAA;
    @(negedge clk);
    chk("rst3 acc1_dev_we", 32'(b3.dev_we), 32'h1);
    chk("rst3 acc1_dwdata", b3.dev_wdata,   32'hAA);
    @(negedge clk);
    chk("rst3 acc2_dev_we", 32'(b3.dev_we), 32'h0);
    chk("rst3 acc2_busy",   32'(b3.busy),   32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst3 after_busy",   32'(b3.busy),    32'h0);
    chk("rst3 after_dev_we", 32'(b3.dev_we),  32'h0);
    chk("rst3 after_done0",  32'(b3.m0_done), 32'h0);
    chk("rst3 after_daddr",  b3.dev_addr,     32'h0);
    reset = 1'b0;
    b3.m0_req = 1'b1; b3.m0_addr = 32'h7f04; b3.m0_we = 1'b0;
    b3.m1_req = 1'b1; b3.m1_addr = 32'h7f14; b3.m1_we = 1'b0;
    b3.dev_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("rst3 tie_first_daddr", b3.dev_addr, 32'h7f04);
    repeat (2) @(negedge clk);
    chk("rst3 tie_nodone", 32'(b3.m0_done | b3.m1_done), 32'h0);
    @(negedge clk);
    chk("rst3 tie_done0",  32'(b3.m0_done), 32'h1);
    chk("rst3 tie_done1",  32'(b3.m1_done), 32'h0);
    chk("rst3 tie_rdata0", b3.m0_rdata,     32'h5A5A5A5A);
    b3.m0_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst3 second_daddr", b3.dev_addr, 32'h7f14);
    repeat (3) @(negedge clk);
    chk("rst3 second_done1", 32'(b3.m1_done), 32'h1);
    chk("rst3 second_rdata1", b3.m1_rdata,    32'h5A5A5A5A);
    b3.m1_req = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
